// File: rtl/icache_refill_ctrl_pkg.sv
// Shared constants for the instruction-cache refill controller: FSM encodings,
// default geometry and the address-split helper.
package icache_refill_ctrl_pkg;

    localparam logic [1:0] ICACHE_IDLE   = 2'b00;
    localparam logic [1:0] ICACHE_REFILL = 2'b01;
    localparam logic [1:0] ICACHE_DONE   = 2'b10;

    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_NUM_LINES  = 16;
    localparam int ICACHE_INST_W     = 32;

    // Byte-offset bits of a line: word select plus the two byte bits.
    function automatic int icache_off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag RAM, valid bits and data array of the direct-mapped instruction cache.
// One asynchronous lookup port, synchronous word / tag+valid / clear-all writes.
module icache_line_store
    import icache_refill_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int NUM_LINES  = ICACHE_NUM_LINES,
    parameter int TAG_W      = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(NUM_LINES)-1:0]  i_rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] i_rd_off,
    output logic [TAG_W-1:0]              o_rd_tag,
    output logic                          o_rd_valid,
    output logic [ICACHE_INST_W-1:0]      o_rd_word,
    input  logic                          i_wr_word_en,
    input  logic [$clog2(NUM_LINES)-1:0]  i_wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] i_wr_off,
    input  logic [ICACHE_INST_W-1:0]      i_wr_word,
    input  logic                          i_wr_tag_en,
    input  logic [TAG_W-1:0]              i_wr_tag,
    input  logic                          i_wr_valid,
    input  logic                          i_clr_all
);

    logic [TAG_W-1:0]         r_tag   [NUM_LINES];
    logic [ICACHE_INST_W-1:0] r_data  [NUM_LINES][LINE_WORDS];
    logic [NUM_LINES-1:0]     r_valid;

    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_word  = r_data[i_rd_idx][i_rd_off];

    // Clear-all first so a line completing in the same cycle still lands with its own valid value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            if (i_clr_all)
                r_valid <= '0;
            if (i_wr_tag_en)
                r_valid[i_wr_idx] <= i_wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_word_en)
            r_data[i_wr_idx][i_wr_off] <= i_wr_word;
        if (i_wr_tag_en)
            r_tag[i_wr_idx] <= i_wr_tag;
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache front end: hit lookup in the request cycle,
// miss refill of one line from external memory word by word, hit/miss counters.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int NUM_LINES  = ICACHE_NUM_LINES,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic [ADDR_W-1:0]        cpu_pc,
    output logic [ICACHE_INST_W-1:0] cpu_inst,
    output logic                     cpu_stall,
    input  logic                     inv_all,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_valid,
    input  logic [ICACHE_INST_W-1:0] mem_rdata,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
);

    localparam int OB    = icache_off_bits(LINE_WORDS);
    localparam int WB    = $clog2(LINE_WORDS);
    localparam int IB    = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - OB - IB;

    logic [1:0]           r_state;
    logic [WB-1:0]        r_word_cnt;
    logic [ADDR_W-OB-1:0] r_line;
    logic                 r_inv_pend;
    logic [31:0]          r_hit_cnt;
    logic [31:0]          r_miss_cnt;

    logic [WB-1:0]            w_off;
    logic [IB-1:0]            w_idx;
    logic [TAG_W-1:0]         w_tag;
    logic [IB-1:0]            w_line_idx;
    logic [TAG_W-1:0]         w_line_tag;
    logic [TAG_W-1:0]         w_rd_tag;
    logic                     w_rd_valid;
    logic [ICACHE_INST_W-1:0] w_rd_word;
    logic                     w_lookup;
    logic                     w_hit;
    logic                     w_miss;
    logic                     w_wr_en;
    logic                     w_last;
    logic                     w_unused_pc;

    assign w_off       = cpu_pc[OB-1:2];
    assign w_idx       = cpu_pc[OB+IB-1:OB];
    assign w_tag       = cpu_pc[ADDR_W-1:OB+IB];
    assign w_unused_pc = ^cpu_pc[1:0];

    // The refill target comes from the latched line address, so a PC redirect cannot retarget it.
    assign w_line_idx = r_line[IB-1:0];
    assign w_line_tag = r_line[ADDR_W-OB-1:IB];

    assign w_lookup = (r_state == ICACHE_IDLE) && cpu_req;
    assign w_hit    = w_lookup && w_rd_valid && (w_rd_tag == w_tag);
    assign w_miss   = w_lookup && !w_hit;
    assign w_wr_en  = (r_state == ICACHE_REFILL) && mem_valid;
    assign w_last   = w_wr_en && (r_word_cnt == WB'(LINE_WORDS - 1));

    icache_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES),
        .TAG_W      (TAG_W)
    ) u_line_store (
        .clk          (clk),
        .rst          (rst),
        .i_rd_idx     (w_idx),
        .i_rd_off     (w_off),
        .o_rd_tag     (w_rd_tag),
        .o_rd_valid   (w_rd_valid),
        .o_rd_word    (w_rd_word),
        .i_wr_word_en (w_wr_en),
        .i_wr_idx     (w_line_idx),
        .i_wr_off     (r_word_cnt),
        .i_wr_word    (mem_rdata),
        .i_wr_tag_en  (w_last),
        .i_wr_tag     (w_line_tag),
        .i_wr_valid   (!(r_inv_pend || inv_all)),
        .i_clr_all    (inv_all)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ICACHE_IDLE;
            r_word_cnt <= '0;
            r_inv_pend <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                ICACHE_IDLE: begin
                    if (w_hit)
                        r_hit_cnt <= r_hit_cnt + 32'd1;
                    if (w_miss) begin
                        r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_word_cnt <= '0;
                        r_inv_pend <= 1'b0;
                        r_state    <= ICACHE_REFILL;
                    end
                end
                ICACHE_REFILL: begin
                    if (inv_all)
                        r_inv_pend <= 1'b1;
                    if (w_wr_en) begin
                        r_word_cnt <= r_word_cnt + WB'(1);
                        if (w_last)
                            r_state <= ICACHE_DONE;
                    end
                end
                ICACHE_DONE: r_state <= ICACHE_IDLE;
                default:     r_state <= ICACHE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_miss)
            r_line <= cpu_pc[ADDR_W-1:OB];
    end

    assign cpu_stall = (r_state != ICACHE_IDLE) || w_miss;
    assign cpu_inst  = w_hit ? w_rd_word : '0;
    assign mem_req   = (r_state == ICACHE_REFILL);
    assign mem_addr  = {r_line, r_word_cnt, 2'b00};
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: a memory responder checks refill
// addresses against a queue, fetch tasks check instructions and stall lengths.
module tb_icache_refill_ctrl;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_pc = '0;
    logic [31:0] cpu_inst;
    logic        cpu_stall;
    logic        inv_all = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int mem_wait = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    logic [31:0] resp_exp;
    logic [31:0] q_addr[$];
    logic [31:0] q_inst[$];

    icache_refill_ctrl #(.LINE_WORDS(LW), .NUM_LINES(16), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_pc    (cpu_pc),
        .cpu_inst  (cpu_inst),
        .cpu_stall (cpu_stall),
        .inv_all   (inv_all),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h10) >> 2);
    endfunction

    // Memory responder: each requested word answered after lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (mem_wait >= lat - 1) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    mem_wait  = 0;
                    checks++;
                    if (q_addr.size() == 0) begin
                        errors++;
                        $display("FAIL mem_addr unexpected request: got %h, expected no request", mem_addr);
                    end else begin
                        resp_exp = q_addr.pop_front();
                        if (mem_addr !== resp_exp) begin
                            errors++;
                            $display("FAIL mem_addr: got %h, expected %h", mem_addr, resp_exp);
                        end
                    end
                end else begin
                    mem_valid = 1'b0;
                    mem_wait++;
                end
            end else begin
                mem_valid = 1'b0;
                mem_wait  = 0;
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input int n_miss, input string nm, input int inv_at);
        int stalls;
        int exp_st;
        logic [31:0] exp_i;
        exp_st = n_miss * (LW * lat + 2);
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_pc  = pc;
        q_inst.push_back(mem_word({pc[31:2], 2'b00}));
        for (int m = 0; m < n_miss; m++)
            for (int k = 0; k < LW; k++)
                q_addr.push_back({pc[31:4], 4'h0} + 32'(4 * k));
        exp_miss += n_miss;
        exp_hit++;
        stalls = 0;
        #1;
        while (cpu_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
            inv_all = (inv_at != 0 && stalls == inv_at) ? 1'b1 : 1'b0;
            #1;
        end
        inv_all = 1'b0;
        checks++;
        if (stalls != exp_st) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d, expected %0d", nm, stalls, exp_st);
        end
        exp_i = q_inst.pop_front();
        checks++;
        if (cpu_inst !== exp_i) begin
            errors++;
            $display("FAIL %s cpu_inst: got %h, expected %h", nm, cpu_inst, exp_i);
        end
    endtask

    task automatic check_counts(input string nm);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s idle stall/mem_req: got %b/%b, expected 0/0", nm, cpu_stall, mem_req);
        end
        checks++;
        if (hit_cnt !== 32'(exp_hit)) begin
            errors++;
            $display("FAIL %s hit_cnt: got %0d, expected %0d", nm, hit_cnt, exp_hit);
        end
        checks++;
        if (miss_cnt !== 32'(exp_miss)) begin
            errors++;
            $display("FAIL %s miss_cnt: got %0d, expected %0d", nm, miss_cnt, exp_miss);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || cpu_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: got stall=%b mem_req=%b inst=%h, expected 0 0 0", cpu_stall, mem_req, cpu_inst);
        end
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset counters: got %0d/%0d, expected 0/0", hit_cnt, miss_cnt);
        end
        rst = 1'b1;
    endtask

    task automatic test_cold_miss();
        fetch(32'h10, 1, "cold_miss_10", 0);
        check_counts("cold_miss");
    endtask

    task automatic test_back_to_back();
        fetch(32'h14, 0, "b2b_14", 0);
        fetch(32'h18, 0, "b2b_18", 0);
        fetch(32'h1C, 0, "b2b_1c", 0);
        check_counts("back_to_back");
    endtask

    task automatic test_evict();
        fetch(32'h110, 1, "evict_110", 0);
        fetch(32'h10, 1, "evict_10", 0);
        check_counts("evict");
    endtask

    task automatic test_redirect();
        int stalls;
        bit switched;
        logic [31:0] exp_i;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_pc  = 32'h20;
        for (int k = 0; k < LW; k++) q_addr.push_back(32'h20 + 32'(4 * k));
        for (int k = 0; k < LW; k++) q_addr.push_back(32'h40 + 32'(4 * k));
        q_inst.push_back(mem_word(32'h40));
        exp_miss += 2;
        exp_hit++;
        stalls = 0;
        switched = 1'b0;
        #1;
        while (cpu_stall && stalls < 200) begin
            if (!switched && mem_req && mem_addr == 32'h28) begin
                cpu_pc = 32'h40;
                switched = 1'b1;
            end
            stalls++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (!switched) begin
            errors++;
            $display("FAIL redirect word2_seen: got 0, expected 1");
        end
        checks++;
        if (stalls != 2 * (LW * lat + 2)) begin
            errors++;
            $display("FAIL redirect stall_cycles: got %0d, expected %0d", stalls, 2 * (LW * lat + 2));
        end
        exp_i = q_inst.pop_front();
        checks++;
        if (cpu_inst !== exp_i) begin
            errors++;
            $display("FAIL redirect cpu_inst: got %h, expected %h", cpu_inst, exp_i);
        end
        check_counts("redirect");
        fetch(32'h20, 0, "redirect_20_hit", 0);
        check_counts("redirect_hit");
    endtask

    task automatic test_invalidate();
        fetch(32'h50, 2, "inv_refill_50", 2);
        check_counts("inv_refill");
        fetch(32'h20, 1, "inv_refill_20", 0);
        fetch(32'h50, 0, "inv_refill_50_hit", 0);
        @(negedge clk);
        cpu_req = 1'b0;
        inv_all = 1'b1;
        @(negedge clk);
        inv_all = 1'b0;
        lat = 2;
        fetch(32'h50, 1, "inv_idle_50_lat2", 0);
        lat = 1;
        fetch(32'h20, 1, "inv_idle_20", 0);
        check_counts("inv_idle");
    endtask

    task automatic test_reset_mid_refill();
        bit found;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_pc  = 32'h60;
        for (int k = 0; k < LW; k++) q_addr.push_back(32'h60 + 32'(4 * k));
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h68) found = 1'b1;
        end
        rst = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid word2_seen: got 0, expected 1");
        end
        checks++;
        if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid mem_req/stall: got %b/%b, expected 0/0", mem_req, cpu_stall);
        end
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid counters: got %0d/%0d, expected 0/0", hit_cnt, miss_cnt);
        end
        rst = 1'b1;
        q_addr.delete();
        exp_hit = 0;
        exp_miss = 0;
        fetch(32'h60, 1, "rst_mid_60", 0);
        fetch(32'h10, 1, "rst_mid_10", 0);
        check_counts("rst_mid");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_evict();
        test_redirect();
        test_invalidate();
        test_reset_mid_refill();
        checks++;
        if (q_addr.size() != 0) begin
            errors++;
            $display("FAIL leftover_mem_requests: got %0d pending, expected 0", q_addr.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
